// File: rtl/btb_if.sv
// Lookup/update/prediction bundle between the fetch front end and the BTB.
interface btb_if #(
  parameter int ADDR_W = 32
);
  logic              flush;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              update_valid;
  logic [ADDR_W-1:0] update_pc;
  logic [ADDR_W-1:0] update_target;
  logic              update_taken;
  logic              pred_valid;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  modport master (
    output flush, lookup_valid, lookup_pc,
    output update_valid, update_pc, update_target, update_taken,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  flush, lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_target, update_taken,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: 2-bit counters, round-robin
// replacement, 1-cycle registered lookup with write-first update bypass.
module btb_assoc #(
  parameter int ADDR_W = 32,
  parameter int SETS   = 256,
  parameter int WAYS   = 2
) (
  input  logic clk,
  input  logic rst,
  btb_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Entry storage; only valid bits and victim pointers are reset.
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [ADDR_W-1:0]         tgt_q  [SETS][WAYS];
  logic [1:0]                cnt_q  [SETS][WAYS];
  logic [PTR_W-1:0]          vptr_q [SETS];

  // Post-update image of the set addressed by the update port.
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              upd_en, set_we, u_hit, any_inv;
  logic [PTR_W-1:0]  u_way, inv_way, vic;
  logic [WAYS-1:0]   n_valid;
  logic [TAG_W-1:0]  n_tag [WAYS];
  logic [ADDR_W-1:0] n_tgt [WAYS];
  logic [1:0]        n_cnt [WAYS];
  logic [PTR_W-1:0]  n_ptr;

  // Lookup side.
  logic [IDX_W-1:0]  l_idx;
  logic [TAG_W-1:0]  l_tag;
  logic              byp, l_hit;
  logic [1:0]        l_cnt;
  logic [ADDR_W-1:0] l_tgt, pc4;

  // Byte-offset bits of the update PC carry no information.
  logic unused_upd_lsb;
  assign unused_upd_lsb = ^bus.update_pc[1:0];

  assign u_idx  = bus.update_pc[IDX_W+1:2];
  assign u_tag  = bus.update_pc[ADDR_W-1:IDX_W+2];
  assign l_idx  = bus.lookup_pc[IDX_W+1:2];
  assign l_tag  = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_en = bus.update_valid && !bus.flush;
  assign pc4    = bus.lookup_pc + ADDR_W'(4);

  // Build the next state of the updated set (hit train or miss allocate).
  always_comb begin
    n_valid = valid_q[u_idx];
    n_ptr   = vptr_q[u_idx];
    for (int w = 0; w < WAYS; w++) begin
      n_tag[w] = tag_q[u_idx][w];
      n_tgt[w] = tgt_q[u_idx][w];
      n_cnt[w] = cnt_q[u_idx][w];
    end
    u_hit   = 1'b0;
    u_way   = '0;
    any_inv = 1'b0;
    inv_way = '0;
    vic     = '0;
    set_we  = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = PTR_W'(w);
      end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[u_idx][w]) begin
        any_inv = 1'b1;
        inv_way = PTR_W'(w);
      end
    if (upd_en) begin
      if (u_hit) begin
        set_we = 1'b1;
        if (bus.update_taken) begin
          n_tgt[u_way] = bus.update_target;
          if (n_cnt[u_way] != 2'd3) n_cnt[u_way] = n_cnt[u_way] + 2'd1;
        end else if (n_cnt[u_way] != 2'd0) begin
          n_cnt[u_way] = n_cnt[u_way] - 2'd1;
        end
      end else if (bus.update_taken) begin
        set_we       = 1'b1;
        vic          = any_inv ? inv_way : vptr_q[u_idx];
        n_valid[vic] = 1'b1;
        n_tag[vic]   = u_tag;
        n_tgt[vic]   = bus.update_target;
        n_cnt[vic]   = 2'd2;
        // Pointer only moves when a live entry is displaced.
        if (!any_inv && WAYS > 1) n_ptr = vptr_q[u_idx] + 1'b1;
      end
    end
  end

  // Tag compare for lookup, reading the post-update set when indexes collide.
  always_comb begin
    byp   = set_we && (l_idx == u_idx);
    l_hit = 1'b0;
    l_cnt = '0;
    l_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (byp ? (n_valid[w] && n_tag[w] == l_tag)
              : (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag)) begin
        l_hit = 1'b1;
        l_cnt = byp ? n_cnt[w] : cnt_q[l_idx][w];
        l_tgt = byp ? n_tgt[w] : tgt_q[l_idx][w];
      end
    end
    if (bus.flush) l_hit = 1'b0;
  end

  // Valid bits and victim pointers: reset/flush clear, else commit set.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q <= '0;
      for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else if (set_we) begin
      valid_q[u_idx] <= n_valid;
      vptr_q[u_idx]  <= n_ptr;
    end
  end

  // Payload storage (tag/target/counter), written with the committed set.
  always_ff @(posedge clk) begin
    if (!rst && set_we) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_q[u_idx][w] <= n_tag[w];
        tgt_q[u_idx][w] <= n_tgt[w];
        cnt_q[u_idx][w] <= n_cnt[w];
      end
    end
  end

  // Registered prediction; non-lookup cycles drop valid and hold the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pred_valid  <= 1'b0;
      bus.pred_hit    <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
    end else begin
      bus.pred_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        bus.pred_hit    <= l_hit;
        bus.pred_taken  <= l_hit && l_cnt[1];
        bus.pred_target <= (l_hit && l_cnt[1]) ? l_tgt : pc4;
      end
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (ADDR_W=32, SETS=256, WAYS=2).
module tb_btb_assoc;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  btb_if #(.ADDR_W(32)) bif ();

  btb_assoc #(.ADDR_W(32), .SETS(256), .WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.flush         = 1'b0;
    bif.lookup_valid  = 1'b0;
    bif.lookup_pc     = '0;
    bif.update_valid  = 1'b0;
    bif.update_pc     = '0;
    bif.update_target = '0;
    bif.update_taken  = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
    bif.update_valid  = 1'b1;
    bif.update_pc     = pc;
    bif.update_target = tg;
    bif.update_taken  = tk;
    tick();
    bif.update_valid  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bif.lookup_valid = 1'b1;
    bif.lookup_pc    = pc;
    tick();
    bif.lookup_valid = 1'b0;
  endtask

  function automatic logic [34:0] obs();
    return {bif.pred_valid, bif.pred_hit, bif.pred_taken, bif.pred_target};
  endfunction

  task automatic test_reset();
    logic [34:0] got;
    idle_inputs();
    rst = 1'b1;
    bif.lookup_valid = 1'b1;
    bif.lookup_pc    = 32'h0000_1000;
    tick(); tick();
    got = obs();
    total++;
    if (got !== 35'h0) $display("FAIL reset_outputs: got %h exp %h", got, 35'h0);
    else passed++;
    rst = 1'b0;
    bif.lookup_valid = 1'b0;
    tick();
    total++;
    if (bif.pred_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b exp 0", bif.pred_valid);
    else passed++;
  endtask

  task automatic test_miss();
    logic [31:0] pcs [3] = '{32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_1002};
    logic [31:0] tgs [3] = '{32'h0000_1004, 32'h0000_0000, 32'h0000_1006};
    logic [34:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      look(pcs[i]);
      got = obs();
      exp = {3'b100, tgs[i]};
      total++;
      if (got !== exp) $display("FAIL miss[%0d]: got %h exp %h", i, got, exp);
      else passed++;
    end
    tick();
    got = obs();
    exp = {3'b000, 32'h0000_1006};
    total++;
    if (got !== exp) $display("FAIL miss_hold: got %h exp %h", got, exp);
    else passed++;
  endtask

  task automatic test_counter();
    logic [34:0] got, exp;
    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    look(32'h0000_1000);
    got = obs(); exp = {3'b111, 32'h0000_2000};
    total++;
    if (got !== exp) $display("FAIL ctr_alloc: got %h exp %h", got, exp); else passed++;
    tick();
    got = obs(); exp = {3'b011, 32'h0000_2000};
    total++;
    if (got !== exp) $display("FAIL ctr_hold: got %h exp %h", got, exp); else passed++;
    upd(32'h0000_1000, 32'h0, 1'b0);
    upd(32'h0000_1000, 32'h0, 1'b0);
    look(32'h0000_1000);
    got = obs(); exp = {3'b110, 32'h0000_1004};
    total++;
    if (got !== exp) $display("FAIL ctr_nt2: got %h exp %h", got, exp); else passed++;
    upd(32'h0000_1000, 32'h0, 1'b0);
    look(32'h0000_1000);
    got = obs(); exp = {3'b110, 32'h0000_1004};
    total++;
    if (got !== exp) $display("FAIL ctr_sat0: got %h exp %h", got, exp); else passed++;
    upd(32'h0000_1000, 32'h0000_2100, 1'b1);
    look(32'h0000_1000);
    got = obs(); exp = {3'b110, 32'h0000_1004};
    total++;
    if (got !== exp) $display("FAIL ctr_one: got %h exp %h", got, exp); else passed++;
    upd(32'h0000_1000, 32'h0000_2200, 1'b1);
    look(32'h0000_1000);
    got = obs(); exp = {3'b111, 32'h0000_2200};
    total++;
    if (got !== exp) $display("FAIL ctr_two: got %h exp %h", got, exp); else passed++;
    upd(32'h0000_1000, 32'h0000_2200, 1'b1);
    upd(32'h0000_1000, 32'h0000_2200, 1'b1);
    upd(32'h0000_1000, 32'h0, 1'b0);
    look(32'h0000_1000);
    got = obs(); exp = {3'b111, 32'h0000_2200};
    total++;
    if (got !== exp) $display("FAIL ctr_sat3: got %h exp %h", got, exp); else passed++;
    upd(32'h0000_7000, 32'h0000_7700, 1'b0);
    look(32'h0000_7000);
    got = obs(); exp = {3'b100, 32'h0000_7004};
    total++;
    if (got !== exp) $display("FAIL miss_nt_noalloc: got %h exp %h", got, exp); else passed++;
  endtask

  task automatic test_evict();
    logic [31:0] pcs [6] = '{32'h1000, 32'h2000, 32'h3000, 32'h2000, 32'h3000, 32'h4000};
    logic        hit [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [34:0] got, exp;
    bif.flush = 1'b1; tick(); bif.flush = 1'b0;
    upd(32'h1000, 32'h1100, 1'b1);
    upd(32'h2000, 32'h2100, 1'b1);
    upd(32'h3000, 32'h3100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) upd(32'h4000, 32'h4100, 1'b1);
      look(pcs[i]);
      got = obs();
      exp = hit[i] ? {3'b111, pcs[i] + 32'h100} : {3'b100, pcs[i] + 32'h4};
      total++;
      if (got !== exp) $display("FAIL evict[%0d]: got %h exp %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_bypass();
    logic [34:0] got, exp;
    bif.update_valid = 1'b1; bif.update_pc = 32'h5000;
    bif.update_target = 32'h5500; bif.update_taken = 1'b1;
    look(32'h5000);
    bif.update_valid = 1'b0;
    got = obs(); exp = {3'b111, 32'h5500};
    total++;
    if (got !== exp) $display("FAIL bypass_alloc: got %h exp %h", got, exp); else passed++;
    bif.update_valid = 1'b1; bif.update_pc = 32'h4000;
    bif.update_target = 32'h0; bif.update_taken = 1'b0;
    look(32'h4000);
    bif.update_valid = 1'b0;
    got = obs(); exp = {3'b110, 32'h4004};
    total++;
    if (got !== exp) $display("FAIL bypass_train: got %h exp %h", got, exp); else passed++;
    look(32'h4000);
    got = obs(); exp = {3'b110, 32'h4004};
    total++;
    if (got !== exp) $display("FAIL bypass_commit: got %h exp %h", got, exp); else passed++;
    look(32'h3000);
    got = obs(); exp = {3'b100, 32'h3004};
    total++;
    if (got !== exp) $display("FAIL bypass_evicted: got %h exp %h", got, exp); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] pcs [4] = '{32'h4000, 32'h5000, 32'h1010, 32'h6000};
    logic [34:0] got, exp;
    upd(32'h1010, 32'h1500, 1'b1);
    bif.flush = 1'b1;
    bif.update_valid = 1'b1; bif.update_pc = 32'h6000;
    bif.update_target = 32'h6600; bif.update_taken = 1'b1;
    look(32'h4000);
    bif.flush = 1'b0; bif.update_valid = 1'b0;
    got = obs(); exp = {3'b100, 32'h4004};
    total++;
    if (got !== exp) $display("FAIL flush_same_cycle: got %h exp %h", got, exp); else passed++;
    for (int i = 0; i < 4; i++) begin
      look(pcs[i]);
      got = obs(); exp = {3'b100, pcs[i] + 32'h4};
      total++;
      if (got !== exp) $display("FAIL flush_after[%0d]: got %h exp %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] upc [4] = '{32'h1000, 32'h2000, 32'h1000, 32'h0};
    logic [31:0] utg [4] = '{32'h1100, 32'h2100, 32'h0,    32'h0};
    logic        utk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        uv  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] lpc [4] = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
    logic [34:0] ex  [4] = '{{3'b100, 32'h2004}, {3'b111, 32'h1100},
                             {3'b111, 32'h2100}, {3'b110, 32'h1004}};
    logic [34:0] got;
    for (int i = 0; i < 4; i++) begin
      bif.update_valid = uv[i]; bif.update_pc = upc[i];
      bif.update_target = utg[i]; bif.update_taken = utk[i];
      bif.lookup_valid = 1'b1; bif.lookup_pc = lpc[i];
      tick();
      got = obs();
      total++;
      if (got !== ex[i]) $display("FAIL b2b[%0d]: got %h exp %h", i, got, ex[i]);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid();
    logic [34:0] got, exp;
    upd(32'h8000, 32'h8800, 1'b1);
    look(32'h8000);
    got = obs(); exp = {3'b111, 32'h8800};
    total++;
    if (got !== exp) $display("FAIL rst_pre: got %h exp %h", got, exp); else passed++;
    rst = 1'b1;
    look(32'h8000);
    rst = 1'b0;
    got = obs();
    total++;
    if (got !== 35'h0) $display("FAIL rst_mid: got %h exp %h", got, 35'h0); else passed++;
    look(32'h8000);
    got = obs(); exp = {3'b100, 32'h8004};
    total++;
    if (got !== exp) $display("FAIL rst_post: got %h exp %h", got, exp); else passed++;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_counter();
    test_evict();
    test_bypass();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, PC and target width in bits.
REQ-002 SHALL provide parameter SETS, default 256, number of sets (power of two, >=2); IDX_W = log2(SETS).
REQ-003 SHALL provide parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-004 SHALL derive tag as pc[ADDR_W-1:IDX_W+2] and index as pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  invalidate all entries.
REQ-008 lookup_valid  input  1  lookup request this cycle.
REQ-009 lookup_pc  input  ADDR_W  PC to predict.
REQ-010 update_valid  input  1  resolved-branch update this cycle.
REQ-011 update_pc  input  ADDR_W  resolved branch PC.
REQ-012 update_target  input  ADDR_W  resolved target.
REQ-013 update_taken  input  1  resolved direction.
REQ-014 pred_valid  output  1  registered prediction present.
REQ-015 pred_hit  output  1  tag match in a valid way.
REQ-016 pred_taken  output  1  predict taken.
REQ-017 pred_target  output  ADDR_W  predicted next PC.

Function
REQ-018 Each entry SHALL hold valid, tag, target (ADDR_W) and a 2-bit saturating counter; each set SHALL hold a round-robin victim pointer (log2(WAYS) bits; absent when WAYS=1).
REQ-019 Lookup latency SHALL be exactly 1 cycle: outputs registered on the edge after lookup_valid=1; pred_valid=0 the cycle after lookup_valid=0, other outputs then hold.
REQ-020 On hit: pred_hit=1, pred_taken=counter[1], pred_target = target if pred_taken else lookup_pc+4 (mod 2^ADDR_W).
REQ-021 On miss: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4; wrap at 0xFFFFFFFC yields 0x00000000.
REQ-022 Update hit, taken: target overwritten, counter incremented saturating at 3.
REQ-023 Update hit, not taken: counter decremented saturating at 0; target unchanged; entry stays valid.
REQ-024 Update miss, taken: allocate; victim = lowest-index invalid way, else way at victim pointer; new entry counter=2, tag/target written, valid=1.
REQ-025 Victim pointer SHALL advance (wrap modulo WAYS) only when a valid way is evicted.
REQ-026 Update miss, not taken: no state change.
REQ-027 Simultaneous lookup and update to the same set SHALL be write-first: prediction reflects the post-update entry state (bypass).
REQ-028 More than one matching way SHALL never arise; allocation only on miss guarantees this.
REQ-029 flush=1 SHALL clear all valid bits and victim pointers at the edge; a same-cycle update is discarded; a same-cycle lookup returns miss.
REQ-030 Updates and lookups SHALL be accepted every cycle, no back-pressure.

Reset
REQ-031 rst=1 SHALL clear all valid bits and victim pointers and drive pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0 at the next edge.
REQ-032 rst SHALL take priority over flush, update and lookup; a lookup in flight is dropped.
REQ-033 Tag, target and counter storage need not be reset.

Verification
REQ-034 After reset, lookup 0x00001000 -> next cycle pred_valid=1, hit=0, taken=0, target=0x00001004.
REQ-035 Update taken pc=0x00001000 tgt=0x00002000, then lookup 0x00001000 -> hit=1, taken=1 (counter 2), target=0x00002000; two not-taken updates -> hit=1, taken=0, target=0x00001004.
REQ-036 WAYS=2, SETS=256: allocate 0x00001000, 0x00002000, 0x00003000 (same index 0) -> 0x00001000 evicted, other two hit; fourth alloc 0x00004000 evicts 0x00002000.
REQ-037 Same-cycle update taken and lookup of 0x00005000 (previously absent) -> lookup result hit=1, taken=1, target=update_target.
REQ-038 Populate entries, assert flush one cycle with concurrent update 0x00006000 -> all later lookups miss, 0x00006000 not allocated.
REQ-039 Assert rst mid-stream with lookup_valid=1 -> next cycle all outputs 0; prior entries miss.
